lcd_cmd_seq: RTL and testbench



---
 rtl/lcd_pkg.sv | 44 ++++
 rtl/lcd_seq_wdt.sv | 44 ++++
 rtl/lcd_cmd_seq.sv | 206 ++++++++++++++++++++
 tb/tb_lcd_cmd_seq.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared definitions for the LCD command sequencer:
//               command code constants, sequencer FSM state encoding and
//               the command-validity helper.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

  // Command codes understood by the LCD controller
  localparam logic [3:0] CMD_WRITE = 4'd0;
  localparam logic [3:0] CMD_UP    = 4'd1;
  localparam logic [3:0] CMD_DOWN  = 4'd2;
  localparam logic [3:0] CMD_LEFT  = 4'd3;
  localparam logic [3:0] CMD_RIGHT = 4'd4;
  localparam logic [3:0] CMD_MAX   = 4'd5;
  localparam logic [3:0] CMD_MIN   = 4'd6;
  localparam logic [3:0] CMD_AVG   = 4'd7;
  localparam logic [3:0] CMD_CCW   = 4'd8;
  localparam logic [3:0] CMD_CW    = 4'd9;
  localparam logic [3:0] CMD_MIRX  = 4'd10;
  localparam logic [3:0] CMD_MIRY  = 4'd11;
  localparam logic [3:0] CMD_NOP   = 4'd15;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_RDY = 3'd1,
    S_FETCH    = 3'd2,
    S_LATCH    = 3'd3,
    S_ISSUE    = 3'd4,
    S_GAP      = 3'd5,
    S_WRITE    = 3'd6,
    S_FIN      = 3'd7
  } seq_state_e;

  // Codes 0..11 are real commands; 12..15 are skipped by the sequencer
  function automatic logic is_valid_cmd(input logic [3:0] code);
    return (code <= CMD_MIRY);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_seq_wdt.sv
`default_nettype none
// ============================================================================
// Module      : lcd_seq_wdt
// Description : Write-completion watchdog. Cleared by load_i, advances on
//               every cycle count_i is high, and flags expire_o on the cycle
//               the count has reached WDT_CYC-1 (i.e. the WDT_CYC-th counted
//               cycle).
// Ports       : clk      - clock
//               reset    - synchronous active-low reset
//               load_i   - clear the counter
//               count_i  - count enable (high while waiting for the write)
//               expire_o - terminal count reached while counting
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_seq_wdt #(
  parameter int unsigned WDT_CYC = 128
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic count_i,
  output logic expire_o
);

  localparam int unsigned CW = (WDT_CYC > 2) ? $clog2(WDT_CYC) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WDT_CYC - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
    end else if (count_i && (cnt_q != C_LAST)) begin
      // Saturate at the terminal value so the counter never wraps
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire_o = count_i && (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/lcd_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module      : lcd_cmd_seq
// Description : LCD command sequencer. Walks the command ROM from address 0,
//               skips codes 12..15, issues codes 0..11 to the LCD controller
//               with a one-cycle cmd_valid, and ends the sequence once a
//               write (code 0) has been acknowledged by lcd_done. Reaching
//               the last ROM address without a write ends with err=1.
// Options     : CMD_SEQ_TIMEOUT_EN - when defined, a WDT_CYC-cycle watchdog
//               aborts a write that never reports lcd_done (err=1).
// Ports       : clk, reset      - clock, synchronous active-low reset
//               start           - launch pulse (ignored while seq_busy)
//               CROM_rd/CROM_A  - ROM read strobe/address
//               CROM_Q          - ROM data, valid one cycle after CROM_rd
//               lcd_busy/done   - controller status
//               cmd/cmd_valid   - command to controller (NOP when idle)
//               seq_busy/done   - sequence status
//               err             - sticky per-sequence error
//               issued_cnt      - commands issued in this sequence
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_cmd_seq
  import lcd_pkg::*;
#(
  parameter int unsigned CMD_AW  = 5,
  parameter int unsigned WDT_CYC = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        CROM_Q,
  output logic              CROM_rd,
  output logic [CMD_AW-1:0] CROM_A,
  input  logic              lcd_busy,
  input  logic              lcd_done,
  output logic [3:0]        cmd,
  output logic              cmd_valid,
  output logic              seq_busy,
  output logic              seq_done,
  output logic              err,
  output logic [CMD_AW:0]   issued_cnt
);

  seq_state_e        state_q;
  logic [CMD_AW-1:0] ptr_q;
  logic [CMD_AW-1:0] ptr_d;
  logic              ptr_last;
  logic              crom_rd_q;
  logic [CMD_AW-1:0] crom_a_q;
  logic [3:0]        cmd_q;
  logic              cmd_valid_q;
  logic              seq_busy_q;
  logic              seq_done_q;
  logic              err_q;
  logic [CMD_AW:0]   issued_q;
  logic              wdt_expire;

  assign ptr_d    = ptr_q + 1'b1;
  assign ptr_last = &ptr_q;

`ifdef CMD_SEQ_TIMEOUT_EN
  logic wdt_load;
  logic wdt_count;

  // Clear on the ISSUE cycle of a write so the first WRITE cycle counts as 0
  assign wdt_load  = (state_q == S_ISSUE) && (cmd_q == CMD_WRITE);
  assign wdt_count = (state_q == S_WRITE);

  lcd_seq_wdt #(
    .WDT_CYC (WDT_CYC)
  ) u_wdt (
    .clk      (clk),
    .reset    (reset),
    .load_i   (wdt_load),
    .count_i  (wdt_count),
    .expire_o (wdt_expire)
  );
`else
  assign wdt_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      crom_rd_q   <= 1'b0;
      crom_a_q    <= '0;
      cmd_q       <= CMD_NOP;
      cmd_valid_q <= 1'b0;
      seq_busy_q  <= 1'b0;
      seq_done_q  <= 1'b0;
      err_q       <= 1'b0;
      issued_q    <= '0;
    end else begin
      case (state_q)
        // FIN restarts exactly like IDLE; start is not looked at elsewhere,
        // which is what makes it ignored while seq_busy is high.
        S_IDLE, S_FIN: begin
          if (start) begin
            state_q    <= S_WAIT_RDY;
            ptr_q      <= '0;
            issued_q   <= '0;
            err_q      <= 1'b0;
            seq_done_q <= 1'b0;
            seq_busy_q <= 1'b1;
          end
        end

        S_WAIT_RDY: begin
          if (!lcd_busy) begin
            state_q   <= S_FETCH;
            crom_rd_q <= 1'b1;
            crom_a_q  <= ptr_q;
          end
        end

        S_FETCH: begin
          state_q   <= S_LATCH;
          crom_rd_q <= 1'b0;
        end

        S_LATCH: begin
          if (is_valid_cmd(CROM_Q)) begin
            state_q     <= S_ISSUE;
            cmd_q       <= CROM_Q;
            cmd_valid_q <= 1'b1;
            issued_q    <= issued_q + 1'b1;
          end else if (ptr_last) begin
            // Skipped code at the final address: ROM exhausted, no write
            state_q    <= S_FIN;
            err_q      <= 1'b1;
            seq_busy_q <= 1'b0;
            seq_done_q <= 1'b1;
          end else begin
            // Skipped code: fetch the next entry straight away
            state_q   <= S_FETCH;
            ptr_q     <= ptr_d;
            crom_rd_q <= 1'b1;
            crom_a_q  <= ptr_d;
          end
        end

        S_ISSUE: begin
          cmd_valid_q <= 1'b0;
          if (cmd_q == CMD_WRITE) begin
            // cmd stays at 0: the controller streams its frame while cmd==0
            state_q <= S_WRITE;
          end else begin
            state_q <= S_GAP;
            cmd_q   <= CMD_NOP;
          end
        end

        S_GAP: begin
          if (ptr_last) begin
            state_q    <= S_FIN;
            err_q      <= 1'b1;
            seq_busy_q <= 1'b0;
            seq_done_q <= 1'b1;
          end else begin
            ptr_q <= ptr_d;
            // WAIT_RDY is passed through in zero cycles when the controller
            // is already ready, keeping the 4-cycle command cadence.
            if (lcd_busy) begin
              state_q <= S_WAIT_RDY;
            end else begin
              state_q   <= S_FETCH;
              crom_rd_q <= 1'b1;
              crom_a_q  <= ptr_d;
            end
          end
        end

        S_WRITE: begin
          if (lcd_done) begin
            state_q    <= S_FIN;
            cmd_q      <= CMD_NOP;
            seq_busy_q <= 1'b0;
            seq_done_q <= 1'b1;
          end else if (wdt_expire) begin
            state_q    <= S_FIN;
            cmd_q      <= CMD_NOP;
            err_q      <= 1'b1;
            seq_busy_q <= 1'b0;
            seq_done_q <= 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign CROM_rd    = crom_rd_q;
  assign CROM_A     = crom_a_q;
  assign cmd        = cmd_q;
  assign cmd_valid  = cmd_valid_q;
  assign seq_busy   = seq_busy_q;
  assign seq_done   = seq_done_q;
  assign err        = err_q;
  assign issued_cnt = issued_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_cmd_seq
// Description : Self-checking bench for lcd_cmd_seq: CROM and controller
//               models, a table of directed ROM images, randomized ROM
//               images against a list-walking reference model, and
//               hand-written reset / busy / write-timeout sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_cmd_seq;

  localparam int AW    = 5;
  localparam int DEPTH = 1 << AW;
  localparam int WDT   = 128;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    CROM_Q = 4'd0;
  logic          CROM_rd;
  logic [AW-1:0] CROM_A;
  logic          lcd_busy = 1'b0;
  logic          lcd_done = 1'b0;
  logic [3:0]    cmd;
  logic          cmd_valid;
  logic          seq_busy;
  logic          seq_done;
  logic          err;
  logic [AW:0]   issued_cnt;

  lcd_cmd_seq #(
    .CMD_AW  (AW),
    .WDT_CYC (WDT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .CROM_Q     (CROM_Q),
    .CROM_rd    (CROM_rd),
    .CROM_A     (CROM_A),
    .lcd_busy   (lcd_busy),
    .lcd_done   (lcd_done),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .seq_busy   (seq_busy),
    .seq_done   (seq_done),
    .err        (err),
    .issued_cnt (issued_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- CROM model: registered read ----------------
  logic [3:0] rom [DEPTH];
  always @(posedge clk) if (CROM_rd) CROM_Q <= rom[CROM_A];

  // ---------------- controller model: done after done_lat write cycles ----
  int done_lat   = 3;
  bit done_never = 1'b0;
  int wcnt       = 0;
  always @(posedge clk) begin
    if (cmd == 4'd0 && !cmd_valid && !done_never) begin
      wcnt     <= wcnt + 1;
      lcd_done <= (wcnt == done_lat);
    end else begin
      wcnt     <= 0;
      lcd_done <= 1'b0;
    end
  end

  // ---------------- issue monitor ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int iss_code[$];
  int iss_cyc[$];
  always @(negedge clk) if (cmd_valid) begin
    iss_code.push_back(int'(cmd));
    iss_cyc.push_back(cyc);
  end

  // ---------------- scoring ----------------
  int n_pass = 0;
  int n_chk  = 0;
  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- reference model: walk the ROM as a list ----------------
  int exp_codes[$];
  int exp_skip[$];   // skipped entries immediately preceding each issue
  bit exp_err;
  function automatic void ref_model();
    int sk;
    sk = 0;
    exp_codes.delete();
    exp_skip.delete();
    exp_err = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      if (rom[a] > 4'd11) begin
        sk++;
      end else begin
        exp_codes.push_back(int'(rom[a]));
        exp_skip.push_back(sk);
        sk = 0;
        if (rom[a] == 4'd0) begin
          exp_err = 1'b0;
          break;
        end
      end
    end
  endfunction

  // ---------------- helpers ----------------
  task automatic do_start;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (seq_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_write(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (seq_busy && cmd == 4'd0 && !cmd_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic load_rom(input logic [15:0] head, input logic [3:0] fill,
                          input logic [3:0] tail);
    for (int a = 0; a < DEPTH; a++) rom[a] = fill;
    for (int a = 0; a < 4; a++) rom[a] = head[a*4 +: 4];
    rom[DEPTH-1] = tail;
  endtask

  // Compare the finished sequence with the reference model
  task automatic compare_ref(input string tag);
    int nmin;
    ref_model();
    chk({tag, " issued_cnt"}, issued_cnt, exp_codes.size());
    chk({tag, " err"}, err, exp_err);
    chk({tag, " seq_busy"}, seq_busy, 0);
    chk({tag, " cmd_nop"}, cmd, 15);
    chk({tag, " n_issues"}, iss_code.size(), exp_codes.size());
    nmin = (iss_code.size() < exp_codes.size()) ? iss_code.size() : exp_codes.size();
    for (int i = 0; i < nmin; i++) begin
      chk($sformatf("%s code[%0d]", tag, i), iss_code[i], exp_codes[i]);
      if (i > 0)
        chk($sformatf("%s spacing[%0d]", tag, i), iss_cyc[i] - iss_cyc[i-1],
            4 + 2 * exp_skip[i]);
    end
  endtask

  // Launch a sequence with lcd_busy held for busy_cyc cycles after start
  task automatic run_seq(input string tag, input int busy_cyc);
    bit ok;
    iss_code.delete();
    iss_cyc.delete();
    lcd_busy = (busy_cyc > 0);
    do_start;
    chk({tag, " seq_busy_after_start"}, seq_busy, 1);
    repeat (busy_cyc) @(posedge clk);
    #1 lcd_busy = 1'b0;
    wait_done(3000, ok);
    chk({tag, " reached_done"}, ok, 1);
    compare_ref(tag);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [15:0] head;     // addresses 0..3, address 0 in bits [3:0]
    logic [3:0]  fill;     // addresses 4..DEPTH-2
    logic [3:0]  tail;     // address DEPTH-1
    int          exp_cnt;
    bit          exp_err;
    int          exp_last; // last issued code (-1: none)
  } vec_t;

  vec_t vecs[8];

  initial begin
    bit ok;
    bit seen;
    int n;
    int r;

    vecs[0] = '{16'h0741, 4'd15, 4'd15,  4, 1'b0,  0};  // 1,4,7,0
    vecs[1] = '{16'h09FD, 4'd15, 4'd15,  2, 1'b0,  0};  // 13,15,9,0
    vecs[2] = '{16'h3333, 4'd3,  4'd3,  32, 1'b1,  3};  // all 3s
    vecs[3] = '{16'h1110, 4'd1,  4'd1,   1, 1'b0,  0};  // write first
    vecs[4] = '{16'hEDCF, 4'd12, 4'd13,  0, 1'b1, -1};  // nothing valid
    vecs[5] = '{16'h0EB5, 4'd15, 4'd15,  3, 1'b0,  0};  // 5,11,14,0
    vecs[6] = '{16'hFFFF, 4'd15, 4'd0,   1, 1'b0,  0};  // write at last addr
    vecs[7] = '{16'hFFFF, 4'd15, 4'd6,   1, 1'b1,  6};  // cmd at last addr

    // ---- reset values ----
    repeat (3) @(negedge clk);
    chk("rst CROM_rd", CROM_rd, 0);
    chk("rst CROM_A", CROM_A, 0);
    chk("rst cmd", cmd, 15);
    chk("rst cmd_valid", cmd_valid, 0);
    chk("rst seq_busy", seq_busy, 0);
    chk("rst seq_done", seq_done, 0);
    chk("rst err", err, 0);
    chk("rst issued_cnt", issued_cnt, 0);
    reset = 1'b1;

    // ---- lcd_busy for 64 cycles after start ----
    load_rom(16'h0741, 4'd15, 4'd15);
    iss_code.delete();
    iss_cyc.delete();
    lcd_busy = 1'b1;
    do_start;
    seen = 1'b0;
    repeat (64) begin
      @(negedge clk);
      if (CROM_rd) seen = 1'b1;
    end
    chk("busy64 no_fetch_while_busy", seen, 0);
    @(posedge clk); #1 lcd_busy = 1'b0;
    @(negedge clk);
    chk("busy64 rd_before_sampled", CROM_rd, 0);
    @(negedge clk);
    chk("busy64 fetch_rd", CROM_rd, 1);
    chk("busy64 fetch_addr", CROM_A, 0);
    wait_done(500, ok);
    chk("busy64 reached_done", ok, 1);
    compare_ref("busy64");
    chk("busy64 seq_done", seq_done, 1);

    // ---- directed table ----
    for (int v = 0; v < 8; v++) begin
      load_rom(vecs[v].head, vecs[v].fill, vecs[v].tail);
      done_lat = v;
      run_seq($sformatf("vec%0d", v), 0);
      chk($sformatf("vec%0d tbl_cnt", v), issued_cnt, vecs[v].exp_cnt);
      chk($sformatf("vec%0d tbl_err", v), err, vecs[v].exp_err);
      chk($sformatf("vec%0d tbl_done", v), seq_done, 1);
      if (vecs[v].exp_last >= 0 && iss_code.size() > 0)
        chk($sformatf("vec%0d tbl_last", v), iss_code[iss_code.size()-1],
            vecs[v].exp_last);
    end

    // ---- start ignored while busy ----
    load_rom(16'h4321, 4'd15, 4'd15);
    rom[4] = 4'd5;
    rom[5] = 4'd0;
    iss_code.delete();
    iss_cyc.delete();
    do_start;
    repeat (9) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(500, ok);
    chk("ign_start reached_done", ok, 1);
    compare_ref("ign_start");

    // ---- randomized ROM images ----
    for (int it = 0; it < 12; it++) begin
      for (int a = 0; a < DEPTH; a++) begin
        r = $urandom_range(0, 19);
        if (r < 4)                       rom[a] = 4'($urandom_range(12, 15));
        else if (r == 19 && (it % 4) != 3) rom[a] = 4'd0;
        else                             rom[a] = 4'($urandom_range(1, 11));
      end
      done_lat = $urandom_range(0, 8);
      run_seq($sformatf("rnd%0d", it), $urandom_range(0, 6));
    end

    // ---- write that never completes ----
    load_rom(16'hFF08, 4'd15, 4'd15);
    done_never = 1'b1;
    do_start;
    wait_write(ok);
    chk("wdt reach_write", ok, 1);
`ifdef CMD_SEQ_TIMEOUT_EN
    n = 1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (seq_done) break;
      n++;
    end
    chk("wdt write_cycles", n, WDT);
    chk("wdt err", err, 1);
    chk("wdt cmd", cmd, 15);
    chk("wdt seq_busy", seq_busy, 0);
    do_start;
    wait_write(ok);
    chk("rstw reach_write", ok, 1);
`else
    n = 0;
    repeat (1000) @(negedge clk);
    chk("nowdt cmd_held", cmd, 0);
    chk("nowdt cmd_valid", cmd_valid, 0);
    chk("nowdt seq_busy", seq_busy, 1);
    chk("nowdt seq_done", seq_done, 0);
`endif

    // ---- reset held low 3 cycles in the middle of a write ----
    repeat (3) @(negedge clk);
    chk("rstw pre cnt", issued_cnt, 2);
    reset = 1'b0;
    @(negedge clk);
    chk("rstw cmd", cmd, 15);
    chk("rstw cmd_valid", cmd_valid, 0);
    chk("rstw seq_busy", seq_busy, 0);
    chk("rstw err", err, 0);
    chk("rstw issued_cnt", issued_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    done_never = 1'b0;

    // ---- recovery after reset ----
    load_rom(16'h0741, 4'd15, 4'd15);
    done_lat = 2;
    run_seq("post_rst", 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
